// File: rtl/timer_pkg.sv
// Shared alarm/timer definitions: FSM state encoding, config register map
// and ctrl word bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } alarm_state_e;

  localparam logic [1:0] CFG_ADDR_COMPARE = 2'd0;
  localparam logic [1:0] CFG_ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] CFG_ADDR_CTRL    = 2'd2;

  localparam int CTRL_ARM_BIT = 0;
  localparam int CTRL_PER_BIT = 1;

endpackage

// File: rtl/timer_alarm_cfg.sv
// Alarm configuration registers (compare, period, periodic) and the
// valid/ready write handshake; ready drops for the single FIRE cycle.
module timer_alarm_cfg
  import timer_pkg::*;
#(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_addr,
  input  logic [TW-1:0] cfg_wdata,
  input  logic          fire_next,
  input  logic          reload,
  output logic [TW-1:0] compare,
  output logic [TW-1:0] period,
  output logic          periodic,
  output logic          ctrl_wr,
  output logic          ctrl_arm
);

  logic [TW-1:0] compare_q, compare_d;
  logic [TW-1:0] period_q, period_d;
  logic          periodic_q, periodic_d;
  logic          ready_q, ready_d;
  logic          accept;

  assign accept    = cfg_valid & ready_q;
  assign ctrl_wr   = accept & (cfg_addr == CFG_ADDR_CTRL);
  assign ctrl_arm  = cfg_wdata[CTRL_ARM_BIT];
  assign cfg_ready = ready_q;
  assign compare   = compare_q;
  assign period    = period_q;
  assign periodic  = periodic_q;

  // Next-state of the register file; reload and writes never coincide since ready is low in FIRE.
  always_comb begin
    compare_d  = compare_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    ready_d    = ~fire_next;
    if (reload) begin
      compare_d = compare_q + period_q;
    end else if (accept) begin
      case (cfg_addr)
        CFG_ADDR_COMPARE: compare_d  = cfg_wdata;
        CFG_ADDR_PERIOD:  period_d   = cfg_wdata;
        CFG_ADDR_CTRL:    periodic_d = cfg_wdata[CTRL_PER_BIT];
        default:          compare_d  = compare_q;
      endcase
    end else begin
      compare_d = compare_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      compare_q  <= {TW{1'b0}};
      period_q   <= {TW{1'b0}};
      periodic_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      compare_q  <= compare_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: rtl/timer_alarm_irq.sv
// Alarm FSM: wrap-safe compare of elapsed seconds against the programmed
// value, one-shot/periodic reload, level irq and saturating missed count.
module timer_alarm_irq
  import timer_pkg::*;
#(
  parameter int TW   = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [TW-1:0]   time_sec,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_addr,
  input  logic [TW-1:0]   cfg_wdata,
  output logic            irq,
  input  logic            irq_ack,
  output logic            armed,
  output logic [CNTW-1:0] missed_cnt
);

  // Due when time_sec is at or past compare, treating the difference as signed.
  function automatic logic is_due(input logic [TW-1:0] now, input logic [TW-1:0] cmp);
    logic [TW-1:0] diff;
    diff = now - cmp;
    return ~diff[TW-1];
  endfunction

  alarm_state_e    state_q, state_d;
  logic            irq_q, irq_d;
  logic            armed_q, armed_d;
  logic [CNTW-1:0] missed_q, missed_d;
  logic [TW-1:0]   compare, period;
  logic            periodic, ctrl_wr, ctrl_arm, reload, fire_next, due;

  timer_alarm_cfg #(.TW(TW)) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .fire_next (fire_next),
    .reload    (reload),
    .compare   (compare),
    .period    (period),
    .periodic  (periodic),
    .ctrl_wr   (ctrl_wr),
    .ctrl_arm  (ctrl_arm)
  );

  assign due        = is_due(time_sec, compare);
  assign fire_next  = (state_d == FIRE);
  assign irq        = irq_q;
  assign armed      = armed_q;
  assign missed_cnt = missed_q;

  // FSM next state; irq is raised on the ARMED->FIRE edge so it rises one cycle after due.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    missed_d = missed_q;
    irq_d    = irq_ack ? 1'b0 : irq_q;
    reload   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && ctrl_arm) begin
          state_d = ARMED;
          armed_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (ctrl_wr && !ctrl_arm) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (due) begin
          state_d = FIRE;
          irq_d   = 1'b1;
          // An acked irq is replaced by the new event, so it does not count as missed.
          if (irq_q && !irq_ack && (missed_q != {CNTW{1'b1}})) begin
            missed_d = missed_q + {{(CNTW-1){1'b0}}, 1'b1};
          end else begin
            missed_d = missed_q;
          end
        end else begin
          state_d = ARMED;
        end
      end
      FIRE: begin
        if (periodic && (period != {TW{1'b0}})) begin
          reload  = 1'b1;
          state_d = ARMED;
        end else begin
          armed_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      armed_q  <= 1'b0;
      missed_q <= {CNTW{1'b0}};
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      armed_q  <= armed_d;
      missed_q <= missed_d;
    end
  end

endmodule
